// File: rtl/equiv_check_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : equiv_check_sequencer_pkg
// Description : Shared state encodings and sizing helpers for the
//               gate-equivalence sweep sequencer.
// Revision    : 1.0  initial release
// ============================================================================
package equiv_check_sequencer_pkg;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_APPLY   = 3'd1;
  localparam logic [2:0] ST_SETTLE  = 3'd2;
  localparam logic [2:0] ST_COMPARE = 3'd3;
  localparam logic [2:0] ST_DONE    = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE    = ST_IDLE,
    S_APPLY   = ST_APPLY,
    S_SETTLE  = ST_SETTLE,
    S_COMPARE = ST_COMPARE,
    S_DONE    = ST_DONE
  } state_t;

  // Width of a down-counter that must hold SETTLE-1 (never narrower than 1).
  function automatic int settle_cnt_w(input int settle);
    return (settle <= 2) ? 1 : $clog2(settle);
  endfunction

endpackage
`default_nettype wire

// File: rtl/equiv_cmp.sv
`default_nettype none
// ============================================================================
// Module      : equiv_cmp
// Description : Combinational three-way comparator. Flags a mismatch when
//               either candidate output differs from the reference output.
// Revision    : 1.0  initial release
// ============================================================================
module equiv_cmp (
  input  logic res_a,
  input  logic res_b,
  input  logic res_ref,
  output logic mismatch
);

  assign mismatch = (res_a != res_ref) | (res_b != res_ref);

endmodule
`default_nettype wire

// File: rtl/equiv_check_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : equiv_check_sequencer
// Description : Walks every input combination of three implementations of
//               one function, waits SETTLE cycles per vector, compares both
//               candidates against the reference and reports a verdict,
//               the mismatch count and the first failing vector.
//               Optional build macro TRUTH_TABLE_EN adds a captured truth
//               table of the reference output (port truth_tbl).
// Revision    : 1.0  initial release
// ============================================================================
module equiv_check_sequencer
  import equiv_check_sequencer_pkg::*;
#(
  parameter int N_IN   = 2,
  parameter int SETTLE = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              res_a,
  input  logic              res_b,
  input  logic              res_ref,
  output logic [N_IN-1:0]   vec_out,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [N_IN:0]     mismatch_cnt,
  output logic [N_IN-1:0]   first_fail_vec,
  output logic              first_fail_valid
`ifdef TRUTH_TABLE_EN
  ,
  output logic [2**N_IN-1:0] truth_tbl
`endif
);

  localparam int              SC_W        = settle_cnt_w(SETTLE);
  localparam logic [SC_W-1:0] SETTLE_LOAD = SC_W'(SETTLE - 1);
  localparam logic [N_IN-1:0] VEC_LAST    = '1;

  state_t          state;
  state_t          state_nxt;
  logic [SC_W-1:0] settle_cnt;
  logic            mismatch;
  logic            accept;
  logic            cmp_exit;
  logic            last_vec;
  logic [N_IN:0]   cnt_nxt;

  equiv_cmp u_cmp (
    .res_a    (res_a),
    .res_b    (res_b),
    .res_ref  (res_ref),
    .mismatch (mismatch)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic and per-cycle strobes for the datapath.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    cmp_exit  = 1'b0;
    last_vec  = (vec_out == VEC_LAST);
    cnt_nxt   = mismatch_cnt + {{N_IN{1'b0}}, mismatch};
    case (state)
      S_IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = S_APPLY;
        end
      end
      S_APPLY:  state_nxt = S_SETTLE;
      S_SETTLE: begin
        if (settle_cnt == '0) state_nxt = S_COMPARE;
      end
      S_COMPARE: begin
        cmp_exit  = 1'b1;
        state_nxt = last_vec ? S_DONE : S_APPLY;
      end
      S_DONE:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Settle counter: loaded in APPLY, counts down through SETTLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      settle_cnt <= '0;
    end else if (state == S_APPLY) begin
      settle_cnt <= SETTLE_LOAD;
    end else if (state == S_SETTLE && settle_cnt != '0) begin
      settle_cnt <= settle_cnt - 1'b1;
    end
  end

  // Vector counter and result registers; everything holds outside a sweep.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vec_out          <= '0;
      busy             <= 1'b0;
      done             <= 1'b0;
      pass             <= 1'b0;
      mismatch_cnt     <= '0;
      first_fail_vec   <= '0;
      first_fail_valid <= 1'b0;
    end else begin
      done <= cmp_exit && last_vec;
      if (accept) begin
        vec_out          <= '0;
        mismatch_cnt     <= '0;
        pass             <= 1'b0;
        first_fail_valid <= 1'b0;
        first_fail_vec   <= '0;
        busy             <= 1'b1;
      end
      if (cmp_exit) begin
        mismatch_cnt <= cnt_nxt;
        if (mismatch && !first_fail_valid) begin
          first_fail_vec   <= vec_out;
          first_fail_valid <= 1'b1;
        end
        // The verdict includes a mismatch found on the final vector.
        if (last_vec) pass    <= (cnt_nxt == '0);
        else          vec_out <= vec_out + 1'b1;
      end
      if (state == S_DONE) busy <= 1'b0;
    end
  end

`ifdef TRUTH_TABLE_EN
  // Reference output captured per vector, indexed by the vector itself.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      truth_tbl <= '0;
    end else if (accept) begin
      truth_tbl <= '0;
    end else if (cmp_exit) begin
      truth_tbl[vec_out] <= res_ref;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_equiv_check_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_equiv_check_sequencer
// Description : Self-checking bench. Two instances (N_IN=2/SETTLE=1 and
//               N_IN=3/SETTLE=3) are driven by truth tables plus fault masks;
//               expectations come from a sweep model over those tables.
// Revision    : 1.0  initial release
// ============================================================================
module tb_equiv_check_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  // Small instance: N_IN=2, SETTLE=1
  logic       s_start, s_res_a, s_res_b, s_res_ref;
  logic [1:0] s_vec, s_ffvec;
  logic       s_busy, s_done, s_pass, s_ffvalid;
  logic [2:0] s_cnt;
  logic [3:0] s_tt;

  // Big instance: N_IN=3, SETTLE=3
  logic       b_start, b_res_a, b_res_b, b_res_ref;
  logic [2:0] b_vec, b_ffvec;
  logic       b_busy, b_done, b_pass, b_ffvalid;
  logic [3:0] b_cnt;
  logic [7:0] b_tt;

  // Function truth tables and per-implementation fault masks.
  logic [7:0] s_rt, s_fa, s_fb, b_rt, b_fa, b_fb;

  equiv_check_sequencer #(.N_IN(2), .SETTLE(1)) dut_s (
    .clk              (clk),
    .rst_n            (rst_n),
    .start            (s_start),
    .res_a            (s_res_a),
    .res_b            (s_res_b),
    .res_ref          (s_res_ref),
    .vec_out          (s_vec),
    .busy             (s_busy),
    .done             (s_done),
    .pass             (s_pass),
    .mismatch_cnt     (s_cnt),
    .first_fail_vec   (s_ffvec),
    .first_fail_valid (s_ffvalid)
`ifdef TRUTH_TABLE_EN
    ,
    .truth_tbl        (s_tt)
`endif
  );

  equiv_check_sequencer #(.N_IN(3), .SETTLE(3)) dut_b (
    .clk              (clk),
    .rst_n            (rst_n),
    .start            (b_start),
    .res_a            (b_res_a),
    .res_b            (b_res_b),
    .res_ref          (b_res_ref),
    .vec_out          (b_vec),
    .busy             (b_busy),
    .done             (b_done),
    .pass             (b_pass),
    .mismatch_cnt     (b_cnt),
    .first_fail_vec   (b_ffvec),
    .first_fail_valid (b_ffvalid)
`ifdef TRUTH_TABLE_EN
    ,
    .truth_tbl        (b_tt)
`endif
  );

`ifndef TRUTH_TABLE_EN
  assign s_tt = '0;
  assign b_tt = '0;
`endif

  // The three "implementations": reference table, candidates = table ^ fault.
  always_comb begin
    s_res_ref = s_rt[s_vec];
    s_res_a   = s_rt[s_vec] ^ s_fa[s_vec];
    s_res_b   = s_rt[s_vec] ^ s_fb[s_vec];
    b_res_ref = b_rt[b_vec];
    b_res_a   = b_rt[b_vec] ^ b_fa[b_vec];
    b_res_b   = b_rt[b_vec] ^ b_fb[b_vec];
  end

  // Observation mux so one sweep task serves both instances.
  logic       sel;
  logic [2:0] m_vec, m_ffvec;
  logic [3:0] m_cnt;
  logic       m_busy, m_done, m_pass, m_ffvalid;
  logic [7:0] m_tt;
  always_comb begin
    m_vec     = sel ? b_vec     : {1'b0, s_vec};
    m_ffvec   = sel ? b_ffvec   : {1'b0, s_ffvec};
    m_cnt     = sel ? b_cnt     : {1'b0, s_cnt};
    m_busy    = sel ? b_busy    : s_busy;
    m_done    = sel ? b_done    : s_done;
    m_pass    = sel ? b_pass    : s_pass;
    m_ffvalid = sel ? b_ffvalid : s_ffvalid;
    m_tt      = sel ? b_tt      : {4'b0, s_tt};
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_start(input logic v);
    if (sel) b_start = v;
    else     s_start = v;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_vec"},     m_vec, 0);
    check({tag, "_busy"},    m_busy, 0);
    check({tag, "_done"},    m_done, 0);
    check({tag, "_pass"},    m_pass, 0);
    check({tag, "_cnt"},     m_cnt, 0);
    check({tag, "_ffvec"},   m_ffvec, 0);
    check({tag, "_ffvalid"}, m_ffvalid, 0);
    check({tag, "_tt"},      m_tt, 0);
  endtask

  // One complete sweep, checked against a model of the whole sweep.
  task automatic run_sweep(input bit big, input logic [7:0] rt, input logic [7:0] fa,
                           input logic [7:0] fb, input bit inject);
    int  n_in, settle, nvec, exp_edges, exp_cnt, exp_first, n;
    bit  exp_valid, seen;
    logic [7:0] mask;
    sel       = big;
    n_in      = big ? 3 : 2;
    settle    = big ? 3 : 1;
    nvec      = 1 << n_in;
    exp_edges = nvec * (settle + 2);
    mask      = 8'((1 << nvec) - 1);
    exp_cnt   = 0;
    exp_valid = 1'b0;
    exp_first = 0;
    for (int v = 0; v < nvec; v++) begin
      if (fa[v] || fb[v]) begin
        exp_cnt++;
        if (!exp_valid) begin
          exp_valid = 1'b1;
          exp_first = v;
        end
      end
    end
    if (big) begin b_rt = rt; b_fa = fa; b_fb = fb; end
    else     begin s_rt = rt; s_fa = fa; s_fb = fb; end

    @(negedge clk);
    drive_start(1'b1);
    @(posedge clk); #1;
    drive_start(1'b0);
    check("busy_after_start", m_busy, 1);
    check("vec_after_start", m_vec, 0);
    check("cnt_after_start", m_cnt, 0);

    n    = 0;
    seen = 1'b0;
    while (!seen && n < exp_edges + 20) begin
      if (inject && n == 2) drive_start(1'b1);
      @(posedge clk); #1;
      n++;
      drive_start(1'b0);
      if (m_done) seen = 1'b1;
    end
    check("done_seen", seen, 1);
    check("done_edge", n, exp_edges);
    check("busy_in_done", m_busy, 1);
    check("pass", m_pass, (exp_cnt == 0));
    check("mismatch_cnt", m_cnt, exp_cnt);
    check("first_fail_valid", m_ffvalid, exp_valid);
    if (exp_valid) check("first_fail_vec", m_ffvec, exp_first);
    check("vec_final", m_vec, nvec - 1);
`ifdef TRUTH_TABLE_EN
    check("truth_tbl", m_tt, rt & mask);
`endif

    // start during the DONE cycle must be ignored
    if (inject) drive_start(1'b1);
    @(posedge clk); #1;
    drive_start(1'b0);
    check("done_pulse_end", m_done, 0);
    check("busy_after_done", m_busy, 0);
    repeat (3) @(posedge clk);
    #1;
    check("idle_busy", m_busy, 0);
    check("idle_done", m_done, 0);
    check("idle_vec_hold", m_vec, nvec - 1);
    check("idle_cnt_hold", m_cnt, exp_cnt);
    check("idle_pass_hold", m_pass, (exp_cnt == 0));
  endtask

  // Asynchronous reset in SETTLE of vector 1 on the small instance.
  task automatic reset_mid_sweep();
    int n;
    sel  = 1'b0;
    s_rt = 8'h08; s_fa = 8'h00; s_fb = 8'h01;
    @(negedge clk);
    s_start = 1'b1;
    @(posedge clk); #1;
    s_start = 1'b0;
    n = 0;
    while (n < 4) begin
      @(posedge clk); #1;
      n++;
    end
    check("pre_reset_vec", m_vec, 1);
    check("pre_reset_cnt", m_cnt, 1);
    #2 rst_n = 1'b0;
    #1;
    check_all_zero("async_reset");
    repeat (3) @(posedge clk);
    #1;
    check("no_done_in_reset", m_done, 0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n   = 1'b0;
    s_start = 1'b0;
    b_start = 1'b0;
    sel     = 1'b0;
    s_rt = '0; s_fa = '0; s_fb = '0;
    b_rt = '0; b_fa = '0; b_fb = '0;
    #12;
    sel = 1'b0; #1; check_all_zero("reset_s");
    sel = 1'b1; #1; check_all_zero("reset_b");
    @(negedge clk);
    rst_n = 1'b1;

    // AND everywhere, NAND on b, single fault on a at 2'b11 with stray starts
    run_sweep(1'b0, 8'h08, 8'h00, 8'h00, 1'b0);
    run_sweep(1'b0, 8'h08, 8'h00, 8'h0F, 1'b0);
    run_sweep(1'b0, 8'h08, 8'h08, 8'h00, 1'b1);
    run_sweep(1'b0, 8'h08, 8'h00, 8'h00, 1'b1);
    reset_mid_sweep();
    run_sweep(1'b0, 8'h08, 8'h00, 8'h00, 1'b0);
    // AND3 on the wide instance, then all-fail
    run_sweep(1'b1, 8'h80, 8'h00, 8'h00, 1'b0);
    run_sweep(1'b1, 8'h80, 8'hFF, 8'h00, 1'b1);

    for (int i = 0; i < 8; i++) begin
      logic [7:0] rt, fa, fb;
      rt = 8'($urandom);
      fa = ($urandom_range(0, 2) == 0) ? 8'h00 : 8'($urandom & $urandom & $urandom);
      fb = ($urandom_range(0, 2) == 0) ? 8'h00 : 8'($urandom & $urandom);
      run_sweep(1'($urandom_range(0, 1)), rt, fa, fb, 1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
